// File: rtl/spi_slave_rx_pkg.sv
// Shared definitions for the SPI slave receiver.
//   CPOL/CPHA : SPI mode 0 (sclk idles low, data sampled on the rising edge)
//   SPI_DATA_W: default word width
//   state_t   : receiver FSM encodings
package spi_slave_rx_pkg;

  localparam logic CPOL       = 1'b0;
  localparam logic CPHA       = 1'b0;
  localparam int   SPI_DATA_W = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/spi_slave_rx_sync.sv
// spi_sync: STAGES-deep synchroniser with asynchronous active-low reset.
//   clk, rst_n : system clock / async reset
//   rst_val    : value every stage takes while in reset (tie to a constant)
//   d          : asynchronous input
//   q          : synchronised output, STAGES clk edges behind d
module spi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rst_val,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ff <= {STAGES{rst_val}};
    else        ff <= {ff[STAGES-2:0], d};

  assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI mode-0 slave receiver, oversampled in the clk domain.
//   clk, rst_n         : system clock, async active-low reset
//   SPI_sclk/csn/mosi  : raw SPI pins from the master (sclk period >= 8 clk)
//   SPI_miso           : echo of the previously received word, MSB first
//   rd_data            : last completed word, held until the next one
//   rd_valid           : 1-clk strobe, rd_data updated
//   frame_err          : 1-clk strobe, csn rose with a partial word pending
//   rx_busy            : high while a frame is in progress
module spi_slave_rx
  import spi_slave_rx_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SPI_sclk,
  input  logic              SPI_csn,
  input  logic              SPI_mosi,
  output logic              SPI_miso,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              frame_err,
  output logic              rx_busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  // Synchronisers: identical depth on all three pins keeps mosi aligned
  // with the sclk edge that samples it.
  logic sclk_s, csn_s, mosi_s;

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .rst_val(CPOL), .d(SPI_sclk), .q(sclk_s));
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_csn (
    .clk(clk), .rst_n(rst_n), .rst_val(1'b1), .d(SPI_csn),  .q(csn_s));
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .rst_val(1'b0), .d(SPI_mosi), .q(mosi_s));

  // Edge detect
  logic sclk_d, csn_d;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sclk_d <= CPOL;
      csn_d  <= 1'b1;
    end else begin
      sclk_d <= sclk_s;
      csn_d  <= csn_s;
    end

  logic sclk_rise, sclk_fall, csn_fall, csn_rise;
  assign sclk_rise =  sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s &  sclk_d;
  assign csn_fall  = ~csn_s  &  csn_d;
  assign csn_rise  =  csn_s  & ~csn_d;

  // FSM: state register
  state_t state, state_nxt;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (csn_fall) state_nxt = ACTIVE;
      ACTIVE:  if (csn_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    rx_busy = 1'b0;
    if (state == ACTIVE) rx_busy = 1'b1;
  end

  // Datapath. rx_sh holds only the DATA_W-1 bits already received; the
  // completing bit comes straight from mosi_s. tx_rest holds the bits still
  // to send after the one currently on SPI_miso.
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-2:0] rx_sh;
  logic [DATA_W-2:0] tx_rest;
  logic [DATA_W-1:0] echo;
  logic [DATA_W-1:0] rx_word;

  assign rx_word = {rx_sh, mosi_s};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bit_cnt   <= '0;
      rx_sh     <= '0;
      tx_rest   <= '0;
      echo      <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      frame_err <= 1'b0;
      SPI_miso  <= 1'b0;
    end else begin
      rd_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          SPI_miso <= 1'b0;
          if (csn_fall) begin
            bit_cnt  <= '0;
            SPI_miso <= echo[DATA_W-1];
            tx_rest  <= echo[DATA_W-2:0];
          end
        end
        ACTIVE: begin
          // csn_rise takes priority over any coincident sclk edge
          if (csn_rise) begin
            if (bit_cnt != '0) frame_err <= 1'b1;
            bit_cnt  <= '0;
            SPI_miso <= 1'b0;
          end else begin
            if (sclk_rise) begin
              rx_sh <= rx_word[DATA_W-2:0];
              if (bit_cnt == LAST_BIT) begin
                rd_data  <= rx_word;
                echo     <= rx_word;
                rd_valid <= 1'b1;
                bit_cnt  <= '0;
              end else begin
                bit_cnt  <= bit_cnt + 1'b1;
              end
            end
            // bit_cnt==0 on a falling edge means a word just completed
            // (mode 0 starts with a rise), so start the next echo word.
            if (sclk_fall) begin
              if (bit_cnt == '0) begin
                SPI_miso <= echo[DATA_W-1];
                tx_rest  <= echo[DATA_W-2:0];
              end else begin
                SPI_miso <= tx_rest[DATA_W-2];
                tx_rest  <= tx_rest << 1;
              end
            end
          end
        end
        default: ;
      endcase
    end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: drives a mode-0 master at sclk = clk/8,
// watches rd_valid/frame_err strobes, checks against hand-computed values.
module tb_spi_slave_rx;

  logic       clk;
  logic       rst_n;
  logic       sclk, csn, mosi;
  logic       miso;
  logic [7:0] rd_data;
  logic       rd_valid, frame_err, rx_busy;

  spi_slave_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .SPI_sclk(sclk), .SPI_csn(csn), .SPI_mosi(mosi), .SPI_miso(miso),
    .rd_data(rd_data), .rd_valid(rd_valid), .frame_err(frame_err),
    .rx_busy(rx_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor
  int         n_vld = 0, n_fe = 0, n_ovl = 0, n_wide = 0;
  logic [7:0] vq[$];
  logic       pv = 1'b0, pf = 1'b0;

  always @(negedge clk) begin
    if (rd_valid) begin
      n_vld++;
      vq.push_back(rd_data);
    end
    if (frame_err) n_fe++;
    if (rd_valid && frame_err) n_ovl++;
    if ((rd_valid && pv) || (frame_err && pf)) n_wide++;
    pv = rd_valid;
    pf = frame_err;
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Send nb bits of tx MSB first; master samples miso on each rising edge.
  // With lat set, the final rising edge also checks rd_valid timing.
  task automatic spi_bits(input logic [7:0] tx, input int nb, input bit lat,
                          output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i >= 8 - nb; i--) begin
      mosi = tx[i];
      wclk(4);
      sclk  = 1'b1;
      rx[i] = miso;
      if (lat && i == 0) begin
        wclk(2);
        chk("lat_pre", rd_valid, 1'b0);
        wclk(1);
        chk("lat_hit", rd_valid, 1'b1);
        wclk(1);
      end else begin
        wclk(4);
      end
      sclk = 1'b0;
    end
  endtask

  task automatic frame_begin();
    csn = 1'b0;
    wclk(8);
  endtask

  task automatic frame_end();
    wclk(4);
    csn = 1'b1;
    wclk(8);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got 0 exp 1");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rx, rx2;
    int v0, f0;

    rst_n = 1'b0; sclk = 1'b0; csn = 1'b1; mosi = 1'b0;
    wclk(3);
    rst_n = 1'b1;
    wclk(5);
    chk("rst_data",  rd_data,   8'h00);
    chk("rst_vld",   rd_valid,  1'b0);
    chk("rst_ferr",  frame_err, 1'b0);
    chk("rst_busy",  rx_busy,   1'b0);
    chk("rst_miso",  miso,      1'b0);

    // single byte 0xA5, first frame echoes the reset echo value 0
    v0 = n_vld; f0 = n_fe;
    frame_begin();
    chk("t1_busy", rx_busy, 1'b1);
    spi_bits(8'hA5, 8, 1'b1, rx);
    frame_end();
    chk("t1_nvld", n_vld - v0, 1);
    chk("t1_qdat", vq.pop_front(), 8'hA5);
    chk("t1_data", rd_data, 8'hA5);
    chk("t1_ferr", n_fe - f0, 0);
    chk("t1_miso", rx, 8'h00);
    chk("t1_busy_end", rx_busy, 1'b0);

    // 0x00 frame: master reads back previous word 0xA5
    v0 = n_vld;
    frame_begin();
    spi_bits(8'h00, 8, 1'b0, rx);
    frame_end();
    chk("t3_miso", rx, 8'hA5);
    chk("t3_nvld", n_vld - v0, 1);
    chk("t3_qdat", vq.pop_front(), 8'h00);

    // back-to-back 0x3C, 0xC3 in one frame
    v0 = n_vld; f0 = n_fe;
    frame_begin();
    spi_bits(8'h3C, 8, 1'b0, rx);
    spi_bits(8'hC3, 8, 1'b0, rx2);
    frame_end();
    chk("t2_nvld",  n_vld - v0, 2);
    chk("t2_q0",    vq.pop_front(), 8'h3C);
    chk("t2_q1",    vq.pop_front(), 8'hC3);
    chk("t2_miso0", rx,  8'h00);
    chk("t2_miso1", rx2, 8'h3C);
    chk("t2_ferr",  n_fe - f0, 0);

    // partial word: csn rises after 5 bits
    v0 = n_vld; f0 = n_fe;
    frame_begin();
    spi_bits(8'hF0, 5, 1'b0, rx);
    frame_end();
    chk("t4_ferr", n_fe - f0, 1);
    chk("t4_nvld", n_vld - v0, 0);
    chk("t4_data", rd_data, 8'hC3);

    // next frame is clean; echo untouched by the partial word
    v0 = n_vld; f0 = n_fe;
    frame_begin();
    spi_bits(8'h5A, 8, 1'b0, rx);
    frame_end();
    chk("t4b_data", rd_data, 8'h5A);
    chk("t4b_nvld", n_vld - v0, 1);
    chk("t4b_qdat", vq.pop_front(), 8'h5A);
    chk("t4b_ferr", n_fe - f0, 0);
    chk("t4b_miso", rx, 8'hC3);

    // sclk activity with csn high is ignored
    v0 = n_vld; f0 = n_fe;
    for (int i = 0; i < 16; i++) begin
      mosi = i[0];
      wclk(4);
      sclk = 1'b1;
      wclk(4);
      sclk = 1'b0;
      if (i == 8) chk("t5_busy_mid", rx_busy, 1'b0);
    end
    wclk(8);
    chk("t5_nvld", n_vld - v0, 0);
    chk("t5_ferr", n_fe - f0, 0);
    chk("t5_busy", rx_busy, 1'b0);
    chk("t5_data", rd_data, 8'h5A);

    // async reset after 3 bits of 0xFF
    frame_begin();
    spi_bits(8'hFF, 3, 1'b0, rx);
    wclk(2);
    rst_n = 1'b0;
    #1;
    chk("t6_data", rd_data,   8'h00);
    chk("t6_busy", rx_busy,   1'b0);
    chk("t6_miso", miso,      1'b0);
    chk("t6_vld",  rd_valid,  1'b0);
    chk("t6_ferr", frame_err, 1'b0);
    csn = 1'b1; sclk = 1'b0; mosi = 1'b0;
    wclk(3);
    rst_n = 1'b1;
    wclk(5);
    v0 = n_vld; f0 = n_fe;
    frame_begin();
    spi_bits(8'h81, 8, 1'b0, rx);
    frame_end();
    chk("t6b_data", rd_data, 8'h81);
    chk("t6b_nvld", n_vld - v0, 1);
    chk("t6b_qdat", vq.pop_front(), 8'h81);
    chk("t6b_ferr", n_fe - f0, 0);
    chk("t6b_miso", rx, 8'h00);

    chk("strobe_ovl",  n_ovl,  0);
    chk("strobe_wide", n_wide, 0);
    chk("q_empty",     vq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
